psevdo_ram_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that turns the 256x9 psevdo_ram_block into a first-in/first-out buffer. It sits directly in front of the RAM block: it accepts a push stream from the upstream stage, drives the RAM write port (DIn/WADDR/WRB) and read port (RADDR/RDB), and returns RAM read data (DO1) to the downstream stage with a valid strobe. The block also provides full/empty/almost flags, an occupancy count and sticky error flags. WCLKS and RCLKS of the RAM are both tied to CLKS.

---
 rtl/psevdo_ram_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_psevdo_ram_fifo_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/psevdo_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// psevdo_ram_fifo_ctrl
//
// Single-clock FIFO controller wrapped around the 256x9 psevdo_ram_block.
// It turns a push/pop stream into RAM write and read strobes. Read data comes
// back from the RAM (DO1) one cycle after the pop, together with POP_VALID.
// The block also provides status flags, an occupancy count and sticky error
// flags. The RAM WCLKS/RCLKS are tied to CLKS outside this block.
//
// Ports:
//   CLKS          in   1  clock, rising edge (also clocks the RAM)
//   RSTB          in   1  asynchronous reset, active-low
//   CLR           in   1  synchronous flush, active-high
//   PUSH          in   1  push request
//   PUSH_DATA     in   9  word to write
//   POP           in   1  pop request
//   POP_DATA      out  9  popped word (straight from DO1)
//   POP_VALID     out  1  POP_DATA valid this cycle
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  out 1  status decoded from count
//   COUNT         out  9  occupancy 0..256
//   OVF, UDF      out  1  sticky: push rejected / pop rejected
//   DIn           out  9  RAM write data
//   WADDR         out  8  RAM write address (write pointer)
//   WRB           out  1  RAM write strobe, active-low
//   RADDR         out  8  RAM read address (read pointer)
//   RDB           out  1  RAM read strobe, active-low
//   DO1           in   9  RAM read data
// ---------------------------------------------------------------------------
module psevdo_ram_fifo_ctrl #(
    parameter int AFULL_THR  = 240,
    parameter int AEMPTY_THR = 16
) (
    input  logic       CLKS,
    input  logic       RSTB,
    input  logic       CLR,
    input  logic       PUSH,
    input  logic [8:0] PUSH_DATA,
    input  logic       POP,
    output logic [8:0] POP_DATA,
    output logic       POP_VALID,
    output logic       FULL,
    output logic       EMPTY,
    output logic       ALMOST_FULL,
    output logic       ALMOST_EMPTY,
    output logic [8:0] COUNT,
    output logic       OVF,
    output logic       UDF,
    output logic [8:0] DIn,
    output logic [7:0] WADDR,
    output logic       WRB,
    output logic [7:0] RADDR,
    output logic       RDB,
    input  logic [8:0] DO1
);

    localparam logic [8:0] AFULL_CNT  = 9'(AFULL_THR);
    localparam logic [8:0] AEMPTY_CNT = 9'(AEMPTY_THR);
    localparam logic [8:0] DEPTH      = 9'd256;

    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr;
    logic [8:0] cnt;
    logic       pop_valid;
    logic       ovf;
    logic       udf;

    logic       full;
    logic       empty;
    logic       wr_en;
    logic       rd_en;

    assign full  = (cnt == DEPTH);
    assign empty = (cnt == 9'd0);

    // RSTB is part of the accept terms so the RAM strobes drop the moment
    // reset is asserted, without waiting for a clock edge.
    assign wr_en = PUSH & ~full  & RSTB & ~CLR;
    assign rd_en = POP  & ~empty & RSTB & ~CLR;

    // Pointers wrap naturally at 8 bits. POP_VALID follows the accepted pop
    // by one edge, matching the RAM's registered DO1.
    always_ff @(posedge CLKS or negedge RSTB) begin
        if (!RSTB) begin
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            cnt       <= 9'd0;
            pop_valid <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else if (CLR) begin
            wr_ptr    <= 8'd0;
            rd_ptr    <= 8'd0;
            cnt       <= 9'd0;
            pop_valid <= 1'b0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 8'd1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 8'd1;
            end
            if (wr_en && !rd_en) begin
                cnt <= cnt + 9'd1;
            end else if (rd_en && !wr_en) begin
                cnt <= cnt - 9'd1;
            end
            pop_valid <= rd_en;
            // Sticky error flags; only reset or CLR clear them.
            if (PUSH && full) begin
                ovf <= 1'b1;
            end
            if (POP && empty) begin
                udf <= 1'b1;
            end
        end
    end

    assign WRB          = ~wr_en;
    assign RDB          = ~rd_en;
    assign WADDR        = wr_ptr;
    assign RADDR        = rd_ptr;
    assign DIn          = PUSH_DATA;
    assign POP_DATA     = DO1;
    assign POP_VALID    = pop_valid;
    assign FULL         = full;
    assign EMPTY        = empty;
    assign ALMOST_FULL  = (cnt >= AFULL_CNT);
    assign ALMOST_EMPTY = (cnt <= AEMPTY_CNT);
    assign COUNT        = cnt;
    assign OVF          = ovf;
    assign UDF          = udf;

endmodule

// File: tb/tb_psevdo_ram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_psevdo_ram_fifo_ctrl
//
// Bench for psevdo_ram_fifo_ctrl. A behavioural 256x9 RAM sits behind the
// controller. The reference FIFO is a plain queue of words. Popped words go
// into an expectation queue that a separate monitor drains on POP_VALID.
// ---------------------------------------------------------------------------
module tb_psevdo_ram_fifo_ctrl;

    localparam int AFULL_THR  = 240;
    localparam int AEMPTY_THR = 16;

    logic       CLKS = 1'b0;
    logic       RSTB;
    logic       CLR;
    logic       PUSH;
    logic [8:0] PUSH_DATA;
    logic       POP;
    logic [8:0] POP_DATA;
    logic       POP_VALID;
    logic       FULL;
    logic       EMPTY;
    logic       ALMOST_FULL;
    logic       ALMOST_EMPTY;
    logic [8:0] COUNT;
    logic       OVF;
    logic       UDF;
    logic [8:0] DIn;
    logic [7:0] WADDR;
    logic       WRB;
    logic [7:0] RADDR;
    logic       RDB;
    logic [8:0] DO1;

    psevdo_ram_fifo_ctrl #(
        .AFULL_THR (AFULL_THR),
        .AEMPTY_THR(AEMPTY_THR)
    ) dut (
        .CLKS        (CLKS),
        .RSTB        (RSTB),
        .CLR         (CLR),
        .PUSH        (PUSH),
        .PUSH_DATA   (PUSH_DATA),
        .POP         (POP),
        .POP_DATA    (POP_DATA),
        .POP_VALID   (POP_VALID),
        .FULL        (FULL),
        .EMPTY       (EMPTY),
        .ALMOST_FULL (ALMOST_FULL),
        .ALMOST_EMPTY(ALMOST_EMPTY),
        .COUNT       (COUNT),
        .OVF         (OVF),
        .UDF         (UDF),
        .DIn         (DIn),
        .WADDR       (WADDR),
        .WRB         (WRB),
        .RADDR       (RADDR),
        .RDB         (RDB),
        .DO1         (DO1)
    );

    always #5 CLKS = ~CLKS;

    // Behavioural RAM: synchronous write, registered read port DO1.
    logic [8:0] mem [256];
    initial DO1 = 9'd0;
    always @(posedge CLKS) begin
        if (!WRB) mem[WADDR] <= DIn;
        if (!RDB) DO1 <= mem[RADDR];
    end

    // Reference state
    logic [8:0] model_q[$];
    logic [8:0] exp_data_q[$];
    logic       exp_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    int         wr_total = 0;
    int         rd_total = 0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Combinational outputs for the current cycle, before the edge.
    task automatic checkOutput(input logic wa, input logic ra);
        int c;
        c = model_q.size();
        check("WRB", 32'(WRB), 32'(!wa));
        check("RDB", 32'(RDB), 32'(!ra));
        check("COUNT", 32'(COUNT), 32'(c));
        check("FULL", 32'(FULL), 32'(c == 256));
        check("EMPTY", 32'(EMPTY), 32'(c == 0));
        check("ALMOST_FULL", 32'(ALMOST_FULL), 32'(c >= AFULL_THR));
        check("ALMOST_EMPTY", 32'(ALMOST_EMPTY), 32'(c <= AEMPTY_THR));
        check("OVF", 32'(OVF), 32'(m_ovf));
        check("UDF", 32'(UDF), 32'(m_udf));
        check("WADDR", 32'(WADDR), 32'(wr_total % 256));
        check("RADDR", 32'(RADDR), 32'(rd_total % 256));
        check("DIn", 32'(DIn), 32'(PUSH_DATA));
        if (!WRB && !RDB) check("addr_collision", 32'(RADDR != WADDR), 32'd1);
    endtask

    // One clock cycle of stimulus; entered and left at posedge+1.
    task automatic applyStimulus(input logic p, input logic [8:0] d, input logic q,
                                 input logic c = 1'b0);
        logic wa, ra, full_now, empty_now;
        PUSH      = p;
        PUSH_DATA = d;
        POP       = q;
        CLR       = c;
        full_now  = (model_q.size() == 256);
        empty_now = (model_q.size() == 0);
        wa = p & !full_now & !c;
        ra = q & !empty_now & !c;
        @(negedge CLKS);
        checkOutput(wa, ra);
        @(posedge CLKS);
        if (c) begin
            model_q.delete();
            wr_total  = 0;
            rd_total  = 0;
            m_ovf     = 1'b0;
            m_udf     = 1'b0;
            exp_valid = 1'b0;
        end else begin
            if (ra) begin
                exp_data_q.push_back(model_q.pop_front());
                rd_total++;
            end
            if (wa) begin
                model_q.push_back(d);
                wr_total++;
            end
            exp_valid = ra;
            if (p && full_now) m_ovf = 1'b1;
            if (q && empty_now) m_udf = 1'b1;
        end
        #1;
        PUSH = 1'b0;
        POP  = 1'b0;
        CLR  = 1'b0;
    endtask

    // Monitor: compares POP_VALID and pops the expected word when valid.
    initial begin
        forever begin
            @(negedge CLKS);
            if (RSTB === 1'b1 || exp_valid) begin
                check("POP_VALID", 32'(POP_VALID), 32'(exp_valid));
                if (POP_VALID === 1'b1 && exp_valid) begin
                    if (exp_data_q.size() == 0) begin
                        check("POP_DATA_queue", 32'd0, 32'd1);
                    end else begin
                        check("POP_DATA", 32'(POP_DATA), 32'(exp_data_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        RSTB = 1'b0;
        CLR = 1'b0;
        PUSH = 1'b0;
        POP = 1'b0;
        PUSH_DATA = 9'd0;
        #1;
        check("rst_COUNT", 32'(COUNT), 32'd0);
        check("rst_EMPTY", 32'(EMPTY), 32'd1);
        check("rst_AEMPTY", 32'(ALMOST_EMPTY), 32'd1);
        check("rst_FULL", 32'(FULL), 32'd0);
        check("rst_AFULL", 32'(ALMOST_FULL), 32'd0);
        check("rst_POP_VALID", 32'(POP_VALID), 32'd0);
        check("rst_OVF", 32'(OVF), 32'd0);
        check("rst_UDF", 32'(UDF), 32'd0);
        check("rst_WRB", 32'(WRB), 32'd1);
        check("rst_RDB", 32'(RDB), 32'd1);
        @(posedge CLKS);
        @(posedge CLKS);
        #1;
        RSTB = 1'b1;

        // Three pushes, three back-to-back pops
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, 9'(i), 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 9'd0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0);

        // Fill completely, overflow, drain in order
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 9'(i), 1'b0);
        applyStimulus(1'b1, 9'h1AA, 1'b0);
        for (int i = 0; i < 256; i++) applyStimulus(1'b0, 9'd0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0);

        // Pop on empty, then flush
        applyStimulus(1'b0, 9'd0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0);

        // Refill with random data, then push+pop while full
        for (int i = 0; i < 256; i++) applyStimulus(1'b1, 9'($urandom), 1'b0);
        applyStimulus(1'b1, 9'($urandom), 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1);

        // Pointer wrap with simultaneous push and pop each cycle
        applyStimulus(1'b1, 9'($urandom), 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 9'($urandom), 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b1);
        applyStimulus(1'b0, 9'd0, 1'b0);

        // Random traffic with occasional flush
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 55), 9'($urandom),
                          1'($urandom_range(0, 99) < 45),
                          1'($urandom_range(0, 199) == 0));
        end
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1);

        // Reset in the middle of a pop stream
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 9'(i + 32), 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b1);
        POP = 1'b1;
        #2;
        RSTB = 1'b0;
        model_q.delete();
        exp_data_q.delete();
        exp_valid = 1'b0;
        wr_total = 0;
        rd_total = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check("midrst_POP_VALID", 32'(POP_VALID), 32'd0);
        check("midrst_COUNT", 32'(COUNT), 32'd0);
        check("midrst_RDB", 32'(RDB), 32'd1);
        check("midrst_WRB", 32'(WRB), 32'd1);
        @(posedge CLKS);
        #1;
        RSTB = 1'b1;
        POP = 1'b0;
        applyStimulus(1'b0, 9'd0, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
